// File: rtl/constraint_sampler_pkg.sv
// constraint_sampler_pkg: shared operator/state enums and LFSR step for the sampler
package constraint_sampler_pkg;

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_NOT
    } op_e;

    typedef enum logic [1:0] {IDLE, GEN, CHECK, DONE} state_e;

    // x^64+x^63+x^61+x^60+1 -> feedback from bits 63, 62, 60, 59
    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    function automatic logic [63:0] lfsr_next(input logic [63:0] s);
        return {s[62:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/constraint_sampler_if.sv
// constraint_sampler_if: request/config/result bundle between a requester and the sampler
interface constraint_sampler_if #(
    parameter int NUM_VARS  = 5,
    parameter int VAR_W     = 6,
    parameter int NUM_CONS  = 8,
    parameter int MAX_TRIES = 256
);
    localparam int IDX_W = NUM_VARS > 1 ? $clog2(NUM_VARS) : 1;
    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    logic                          req_valid;
    logic                          req_ready;
    logic [63:0]                   cfg_seed;
    logic [NUM_CONS-1:0]           cfg_en;
    logic [NUM_CONS*3-1:0]         cfg_op;
    logic [NUM_CONS*IDX_W-1:0]     cfg_a;
    logic [NUM_CONS*IDX_W-1:0]     cfg_b;
    logic                          out_valid;
    logic                          out_ready;
    logic [NUM_VARS*VAR_W-1:0]     out_vars;
    logic                          out_ok;
    logic [TRY_W-1:0]              out_tries;

    modport master (
        output req_valid, cfg_seed, cfg_en, cfg_op, cfg_a, cfg_b, out_ready,
        input  req_ready, out_valid, out_vars, out_ok, out_tries
    );

    modport slave (
        input  req_valid, cfg_seed, cfg_en, cfg_op, cfg_a, cfg_b, out_ready,
        output req_ready, out_valid, out_vars, out_ok, out_tries
    );

endinterface

// File: rtl/constraint_sampler_eval.sv
// constraint_eval: combinational check of one constraint, met when the operator result is non-zero
module constraint_eval
    import constraint_sampler_pkg::*;
#(
    parameter int VAR_W = 6
) (
    input  logic [VAR_W-1:0] a,
    input  logic [VAR_W-1:0] b,
    input  op_e              op,
    output logic             met
);
    logic [VAR_W:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};

    // logical shifts by VAR_W or more already yield zero
    always_comb begin
        case (op)
            OP_ADD:  met = |sum;
            OP_SUB:  met = |(a - b);
            OP_AND:  met = |(a & b);
            OP_OR:   met = |(a | b);
            OP_XOR:  met = |(a ^ b);
            OP_SHL:  met = |(a << b);
            OP_SHR:  met = |(a >> b);
            default: met = |(~a);
        endcase
    end

endmodule

// File: rtl/constraint_sampler.sv
// constraint_sampler: LFSR-driven rejection sampler that retries candidates until all enabled constraints hold
module constraint_sampler
    import constraint_sampler_pkg::*;
#(
    parameter int NUM_VARS  = 5,
    parameter int VAR_W     = 6,
    parameter int NUM_CONS  = 8,
    parameter int MAX_TRIES = 256
) (
    input logic                 clk,
    input logic                 rst_n,
    constraint_sampler_if.slave bus
);
    localparam int IDX_W = NUM_VARS > 1 ? $clog2(NUM_VARS) : 1;
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam int VEC_W = NUM_VARS * VAR_W;

    if (VEC_W > 64 || MAX_TRIES < 1) begin : g_bad_params
        $fatal(1, "constraint_sampler: need NUM_VARS*VAR_W <= 64 and MAX_TRIES >= 1");
    end

    state_e                    state;
    logic [63:0]               lfsr;
    logic [63:0]               nxt;
    logic [NUM_CONS-1:0]       en;
    logic [NUM_CONS*3-1:0]     op;
    logic [NUM_CONS*IDX_W-1:0] ia;
    logic [NUM_CONS*IDX_W-1:0] ib;
    logic [VEC_W-1:0]          vars;
    logic                      ok;
    logic [TRY_W-1:0]          tries;
    logic                      rdy;
    logic                      vld;
    logic [NUM_CONS-1:0]       met;
    logic                      all_met;

    assign nxt     = lfsr_next(lfsr);
    assign all_met = &(met | ~en);

    // an index past the last variable shifts everything out and reads as zero
    for (genvar c = 0; c < NUM_CONS; c++) begin : g_con
        logic [IDX_W-1:0] xa;
        logic [IDX_W-1:0] xb;
        assign xa = ia[c*IDX_W +: IDX_W];
        assign xb = ib[c*IDX_W +: IDX_W];
        constraint_eval #(.VAR_W(VAR_W)) u_eval (
            .a   (VAR_W'(vars >> (xa * VAR_W))),
            .b   (VAR_W'(vars >> (xb * VAR_W))),
            .op  (op_e'(op[c*3 +: 3])),
            .met (met[c])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            lfsr  <= 64'd1;
            en    <= '0;
            op    <= '0;
            ia    <= '0;
            ib    <= '0;
            vars  <= '0;
            ok    <= 1'b0;
            tries <= '0;
            rdy   <= 1'b1;
            vld   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    state <= GEN;
                    rdy   <= 1'b0;
                    lfsr  <= bus.cfg_seed == 64'd0 ? 64'd1 : bus.cfg_seed;
                    en    <= bus.cfg_en;
                    op    <= bus.cfg_op;
                    ia    <= bus.cfg_a;
                    ib    <= bus.cfg_b;
                    tries <= '0;
                end
                GEN: begin
                    state <= CHECK;
                    lfsr  <= nxt;
                    vars  <= nxt[VEC_W-1:0];
                    tries <= tries + 1'b1;
                end
                CHECK: if (all_met || tries == TRY_W'(MAX_TRIES)) begin
                    state <= DONE;
                    ok    <= all_met;
                    vld   <= 1'b1;
                end else begin
                    state <= GEN;
                end
                DONE: if (bus.out_ready) begin
                    state <= IDLE;
                    vld   <= 1'b0;
                    rdy   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready = rdy;
    assign bus.out_valid = vld;
    assign bus.out_vars  = vars;
    assign bus.out_ok    = ok;
    assign bus.out_tries = tries;

endmodule

// File: tb/tb_constraint_sampler.sv
// tb_constraint_sampler: directed and randomized requests checked against a behavioural sampler model
module tb_constraint_sampler;
    import constraint_sampler_pkg::*;

    localparam int NV = 5;
    localparam int VW = 6;
    localparam int NC = 8;
    localparam int MT = 4;
    localparam int W  = NV * VW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    constraint_sampler_if #(.NUM_VARS(NV), .VAR_W(VW), .NUM_CONS(NC), .MAX_TRIES(MT)) bus ();

    constraint_sampler #(.NUM_VARS(NV), .VAR_W(VW), .NUM_CONS(NC), .MAX_TRIES(MT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [1:0] e2a, e2b;
    logic [5:0] e6a, e6b;
    op_e        e2op, e6op;
    logic       e2met, e6met;

    constraint_eval #(.VAR_W(2)) u_e2 (.a(e2a), .b(e2b), .op(e2op), .met(e2met));
    constraint_eval #(.VAR_W(6)) u_e6 (.a(e6a), .b(e6b), .op(e6op), .met(e6met));

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit op_met(int code, int x, int y);
        int m = (1 << VW) - 1;
        case (code)
            0: return x + y != 0;
            1: return ((x - y) & m) != 0;
            2: return (x & y) != 0;
            3: return (x | y) != 0;
            4: return (x ^ y) != 0;
            5: return y < VW && ((x << y) & m) != 0;
            6: return y < VW && (x >> y) != 0;
            default: return (~x & m) != 0;
        endcase
    endfunction

    function automatic int var_of(logic [W-1:0] v, int idx);
        return idx < NV ? int'((v >> (idx * VW)) & ((1 << VW) - 1)) : 0;
    endfunction

    // rejection sampling: step the polynomial LFSR, accept the first candidate satisfying every enabled rule
    function automatic void model(input logic [63:0] seed, input logic [7:0] en,
                                  input logic [23:0] op, input logic [23:0] a, input logic [23:0] b,
                                  output logic [W-1:0] vars, output bit ok, output int tries);
        logic [63:0] s;
        s = seed == 64'd0 ? 64'd1 : seed;
        ok = 1'b0;
        tries = 0;
        vars = '0;
        while (!ok && tries < MT) begin
            s = {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
            tries++;
            vars = s[W-1:0];
            ok = 1'b1;
            for (int c = 0; c < NC; c++) begin
                if (en[c] && !op_met(int'((op >> (3*c)) & 7), var_of(vars, int'((a >> (3*c)) & 7)),
                                     var_of(vars, int'((b >> (3*c)) & 7))))
                    ok = 1'b0;
            end
        end
    endfunction

    task automatic run_req(input logic [63:0] seed, input logic [7:0] en, input logic [23:0] op,
                           input logic [23:0] a, input logic [23:0] b, input int hold,
                           output logic [W-1:0] got_vars, output int got_tries);
        logic [W-1:0] ev;
        bit           eok;
        int           et;
        int           cyc;
        model(seed, en, op, a, b, ev, eok, et);
        bus.req_valid = 1'b1;
        bus.cfg_seed  = seed;
        bus.cfg_en    = en;
        bus.cfg_op    = op;
        bus.cfg_a     = a;
        bus.cfg_b     = b;
        @(posedge clk);
        @(negedge clk);
        check("busy_ready", 64'(bus.req_ready), 64'd0);
        cyc = 0;
        while (!bus.out_valid && cyc < 100) begin
            bus.req_valid = 1'($urandom);
            bus.cfg_seed  = {$urandom, $urandom};
            bus.cfg_en    = 8'($urandom);
            bus.cfg_op    = 24'($urandom);
            bus.cfg_a     = 24'($urandom);
            bus.cfg_b     = 24'($urandom);
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        got_vars  = bus.out_vars;
        got_tries = int'(bus.out_tries);
        check("latency", 64'(cyc), 64'(2 * et));
        check("out_ok", 64'(bus.out_ok), 64'(eok));
        check("out_tries", 64'(bus.out_tries), 64'(et));
        check("out_vars", 64'(bus.out_vars), 64'(ev));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_ready", 64'(bus.req_ready), 64'd0);
            check("hold_vars", 64'(bus.out_vars), 64'(ev));
            check("hold_ok", 64'(bus.out_ok), 64'(eok));
            check("hold_tries", 64'(bus.out_tries), 64'(et));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("release_ready", 64'(bus.req_ready), 64'd1);
        check("release_valid", 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        logic [W-1:0] gv;
        int           gt;
        logic [23:0]  ra, rb;
        bus.req_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.cfg_seed  = '0;
        bus.cfg_en    = '0;
        bus.cfg_op    = '0;
        bus.cfg_a     = '0;
        bus.cfg_b     = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(bus.req_ready), 64'd1);
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_vars", 64'(bus.out_vars), 64'd0);
        check("rst_ok", 64'(bus.out_ok), 64'd0);
        check("rst_tries", 64'(bus.out_tries), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_req(64'd1, 8'h00, 24'h0, 24'h0, 24'h0, 0, gv, gt);
        check("s1_vars", 64'(gv), 64'd2);
        check("s1_tries", 64'(gt), 64'd1);

        run_req(64'd1, 8'h01, 24'h4, 24'h0, 24'h0, 0, gv, gt);
        check("s2_vars", 64'(gv), 64'd16);
        check("s2_tries", 64'(gt), 64'd4);

        e2op = OP_ADD; e2a = 2'b11; e2b = 2'b01;
        e6op = OP_SHR; e6a = 6'h3F; e6b = 6'd6;
        #1;
        check("eval_add_carry", 64'(e2met), 64'd1);
        check("eval_shr_6", 64'(e6met), 64'd0);
        e2a = 2'b00; e2b = 2'b00;
        e6op = OP_NOT;
        #1;
        check("eval_add_zero", 64'(e2met), 64'd0);
        check("eval_not_ones", 64'(e6met), 64'd0);
        e6op = OP_SHL; e6a = 6'h01; e6b = 6'd5;
        #1;
        check("eval_shl_5", 64'(e6met), 64'd1);
        e6b = 6'd6;
        #1;
        check("eval_shl_6", 64'(e6met), 64'd0);

        run_req({$urandom, $urandom}, 8'h03, 24'o23, 24'o10, 24'o42, 5, gv, gt);

        bus.req_valid = 1'b1;
        bus.cfg_seed  = 64'h1234_5678_9ABC_DEF0;
        bus.cfg_en    = 8'h01;
        bus.cfg_op    = 24'h4;
        bus.cfg_a     = '0;
        bus.cfg_b     = '0;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_ready", 64'(bus.req_ready), 64'd1);
        check("midrst_tries", 64'(bus.out_tries), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_req(64'd1, 8'h00, 24'h0, 24'h0, 24'h0, 0, gv, gt);
        check("s6_vars", 64'(gv), 64'd2);

        run_req(64'd0, 8'h00, 24'h0, 24'h0, 24'h0, 1, gv, gt);

        for (int n = 0; n < 30; n++) begin
            ra = '0;
            rb = '0;
            for (int c = 0; c < NC; c++) begin
                ra |= 24'($urandom_range(0, NV - 1)) << (3 * c);
                rb |= 24'($urandom_range(0, NV - 1)) << (3 * c);
            end
            run_req({$urandom, $urandom}, 8'($urandom & $urandom), 24'($urandom), ra, rb,
                    int'($urandom_range(0, 2)), gv, gt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/constraint_sampler.md
CONSTRAINT_SAMPLER -- requirements
Module: constraint_sampler

Interface
REQ-001 The block SHALL use these parameters: NUM_VARS default 5, number of random variables; VAR_W default 6, width of each variable; NUM_CONS default 8, number of constraints; MAX_TRIES default 256, candidates per request before giving up.
REQ-002 NUM_VARS*VAR_W SHALL be at most 64, and MAX_TRIES SHALL be at least 1; elaboration fails otherwise.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Port list (name, direction, width, meaning):
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- req_valid  in  1  sample request.
- req_ready  out  1  block idle and accepting a request.
- cfg_seed  in  64  LFSR seed, loaded on request accept.
- cfg_en  in  NUM_CONS  per-constraint enable.
- cfg_op  in  NUM_CONS*3  per-constraint operator code.
- cfg_a  in  NUM_CONS*clog2(NUM_VARS)  operand A variable index.
- cfg_b  in  NUM_CONS*clog2(NUM_VARS)  operand B variable index.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_vars  out  NUM_VARS*VAR_W  sampled variables; var_i occupies bits [i*VAR_W +: VAR_W].
- out_ok  out  1  1 = all enabled constraints met; 0 = timeout.
- out_tries  out  clog2(MAX_TRIES+1)  number of candidates evaluated.

Function
REQ-005 Operator codes SHALL be:
- 0 ADD: a+b, evaluated at VAR_W+1 bits so the carry counts.
- 1 SUB: a-b, at VAR_W bits.
- 2 AND, 3 OR, 4 XOR: at VAR_W bits.
- 5 SHL: a<<b, truncated to VAR_W bits.
- 6 SHR: a>>b.
- 7 NOT: ~a; b is ignored.
- For SHL and SHR, a shift amount of VAR_W or more SHALL give 0.
REQ-006 A constraint SHALL be met when it is disabled, or when the OR-reduction of its operator result is 1.
REQ-007 Each cfg_* input SHALL be sampled on request accept and held internally until the result is consumed.
REQ-008 Candidate generation SHALL use a 64-bit Fibonacci LFSR with polynomial x^64+x^63+x^61+x^60+1.
- It is loaded with cfg_seed on accept; a zero seed is replaced by 1.
- It advances exactly once per try.
- Candidate var_i SHALL be LFSR bits [i*VAR_W +: VAR_W] after that advance.
REQ-009 The state machine SHALL have the states IDLE, GEN, CHECK and DONE.
- IDLE -> GEN on req_valid && req_ready.
- GEN: advance the LFSR and register the candidate; -> CHECK.
- CHECK: evaluate the registered candidate. If all constraints are met -> DONE with ok=1. Otherwise, if tries==MAX_TRIES -> DONE with ok=0. Otherwise -> GEN.
- DONE -> IDLE on out_valid && out_ready.
REQ-010 Each try SHALL take 2 cycles; a first-try success SHALL assert out_valid 2 cycles after the accept edge.
REQ-011 req_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-012 While out_valid=1 and out_ready=0, out_vars, out_ok and out_tries SHALL hold stable.
REQ-013 On timeout, out_vars SHALL hold the last candidate evaluated.
REQ-014 out_tries SHALL count tries starting at 1 and SHALL never exceed MAX_TRIES.
REQ-015 req_valid SHALL be ignored outside IDLE, and out_ready SHALL be ignored outside DONE.
REQ-016 The LFSR state SHALL persist across requests only until the next accept, which always reloads cfg_seed.

Reset
REQ-017 On rst_n=0, asynchronously:
- the state SHALL be IDLE and the LFSR SHALL be 1;
- req_ready=1, out_valid=0, out_vars=0, out_ok=0, out_tries=0.
REQ-018 Reset mid-request SHALL abandon the request with no output; the first accept after reset SHALL behave as a fresh request.

Structure
REQ-019 A shared package constraint_sampler_pkg SHALL hold the operator enum (3 bits), the state enum and the LFSR tap constant.
REQ-020 The single sub-module constraint_eval SHALL be combinational: two VAR_W operands plus an op code in, the met bit out. It is instantiated NUM_CONS times.

Verification
REQ-021 Directed scenarios the bench SHALL cover:
- All constraints disabled, seed=1 -> out_valid 2 cycles after accept; out_ok=1; out_tries=1; out_vars = LFSR state after one advance from 1.
- Single constraint XOR(var_0,var_0) enabled, MAX_TRIES=4 -> out_valid 8 cycles after accept; out_ok=0; out_tries=4.
- ADD with VAR_W=2, a=2'b11, b=2'b01 applied to constraint_eval -> met=1, because the carry counts.
- SHR with a=6'h3F, b=6 -> met=0; NOT with a=6'h3F -> met=0.
- Result pending, out_ready held 0 for 5 cycles -> outputs stable and req_ready=0; out_ready=1 -> IDLE next cycle.
- rst_n pulsed low during CHECK -> out_valid=0 immediately and req_ready=1; a new request with seed=1 reproduces the first scenario.
